// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory read-modify-write controller.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ST,
        RMW,
        ERR
    } state_t;

    // Size code 2'b11 is illegal and always reported as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return (lane != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] q,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        sx_byte;
    logic        sx_half;

    always_comb begin
        ld_byte = q[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? q[31:16] : q[15:0];
        sx_byte = ld_byte[7] & ~is_unsigned;
        sx_half = ld_half[15] & ~is_unsigned;

        case (size)
            SZ_B:    rdata = {{24{sx_byte}}, ld_byte};
            SZ_H:    rdata = {{16{sx_half}}, ld_half};
            default: rdata = q;
        endcase

        merged = q;
        case (size)
            SZ_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (lane[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Load/store front end for a single-port synchronous RAM without byte enables;
// sub-word stores are done as a read followed by a merged write.
module dmem_rmw_ctrl
    import dmem_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [1:0]    REQ_SIZE,
    input  logic          REQ_UNSIGNED,
    input  logic [AW+1:0] REQ_ADDR,
    input  logic [31:0]   REQ_WDATA,
    output logic          RSP_VALID,
    output logic [31:0]   RSP_RDATA,
    output logic          RSP_ERR,
    output logic [AW-1:0] RAM_ADR,
    output logic [31:0]   RAM_D,
    output logic          RAM_WE,
    input  logic [31:0]   RAM_Q
);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          xfer;
    logic          req_mis;
    logic [31:0]   ext_data;
    logic [31:0]   mrg_data;

    assign REQ_READY = (state == IDLE) & RST_N;
    assign xfer      = REQ_VALID & REQ_READY;
    assign req_mis   = misaligned(REQ_SIZE, REQ_ADDR[1:0]);

    dmem_lane_align u_align (
        .q           (RAM_Q),
        .wdata       (r_wdata),
        .lane        (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_uns),
        .rdata       (ext_data),
        .merged      (mrg_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (xfer) begin
            r_size  <= REQ_SIZE;
            r_uns   <= REQ_UNSIGNED;
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // RAM port is driven straight from the request in the transfer cycle so
    // the read (or SW write) happens without an extra cycle of latency.
    always_comb begin
        state_nxt = state;
        RAM_ADR   = r_addr[AW+1:2];
        RAM_D     = mrg_data;
        RAM_WE    = 1'b0;
        RSP_VALID = 1'b0;
        RSP_ERR   = 1'b0;
        RSP_RDATA = '0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    RAM_ADR = REQ_ADDR[AW+1:2];
                    RAM_D   = REQ_WDATA;
                    if (req_mis) begin
                        state_nxt = ERR;
                    end else if (!REQ_WE) begin
                        state_nxt = LD;
                    end else if (REQ_SIZE == SZ_W) begin
                        RAM_WE    = 1'b1;
                        state_nxt = ST;
                    end else begin
                        state_nxt = RMW;
                    end
                end
            end
            LD: begin
                RSP_VALID = 1'b1;
                RSP_RDATA = ext_data;
                state_nxt = IDLE;
            end
            ST: begin
                RSP_VALID = 1'b1;
                state_nxt = IDLE;
            end
            RMW: begin
                RAM_WE    = 1'b1;
                state_nxt = ST;
            end
            ERR: begin
                RSP_VALID = 1'b1;
                RSP_ERR   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
